bcd_to_bin_converter: RTL and testbench



---
 rtl/bcd_to_bin_converter.sv | 83 ++++++++
 tb/tb_bcd_to_bin_converter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter: sequential reverse double-dabble, packed BCD in, binary out, one shift step per clock
//   params : DIGITS BCD digits on bcd_in, OUT_W result width (>= 4*DIGITS, zero-extended)
//   in     : clk, rst_n (async active-low), bcd_in, in_valid, out_ready
//   out    : in_ready (IDLE), bin_out (held while out_valid), out_valid, err (non-BCD input, only with BCD_CHECK_EN)
//   macro  : BCD_CHECK_EN enables input digit checking; undefined -> err is always 0
module bcd_to_bin_converter #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);
    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(BW+1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [BW-1:0] bcd_reg, bin_reg, bcd_raw, bcd_sh, bin_sh;
    logic [CW-1:0] cnt;
    logic bad_in, bad_reg, finish;
    // one step: shift right across both halves, then pull every digit that reached >= 8 back by 3
    always_comb begin
        {bcd_raw, bin_sh} = {bcd_reg, bin_reg} >> 1;
        bcd_sh = bcd_raw;
        for (int d = 0; d < DIGITS; d++)
            bcd_sh[4*d+:4] = bcd_raw[4*d+:4] >= 4'd8 ? bcd_raw[4*d+:4] - 4'd3 : bcd_raw[4*d+:4];
    end
`ifdef BCD_CHECK_EN
    always_comb begin
        bad_in = 1'b0;
        for (int d = 0; d < DIGITS; d++)
            bad_in = bad_in | (bcd_in[4*d+:4] > 4'd9);
    end
`else
    assign bad_in = 1'b0;
`endif
    // a bad input spends a single edge in SHIFT, so the error result appears one edge after accept
    assign finish    = bad_reg || cnt == CW'(BW);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE  && in_valid)  ? SHIFT :
                   (state == SHIFT && finish)    ? DONE  :
                   (state == DONE  && out_ready) ? IDLE  : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bad_reg <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                bcd_reg <= bcd_in;
                bin_reg <= '0;
                cnt     <= '0;
                bad_reg <= bad_in;
            end else if (state == SHIFT) begin
                if (finish) begin
                    bin_out <= bad_reg ? '0 : OUT_W'(bin_reg);
                    err     <= bad_reg;
                end else begin
                    bcd_reg <= bcd_sh;
                    bin_reg <= bin_sh;
                    cnt     <= cnt + 1'b1;
                end
            end else if (state == DONE && out_ready) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// tb_bcd_to_bin_converter: directed + randomized checks of bcd_to_bin_converter against a decimal reference model
module tb_bcd_to_bin_converter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] bin_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err;
    int tests = 0;
    int fails = 0;

    bcd_to_bin_converter #(.DIGITS(3), .OUT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
        .bin_out(bin_out), .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one conversion, optionally toggling in_valid while busy, stall the consumer, then hand off
    task automatic run(input logic [11:0] bcd, input int stall, input int exp_lat,
                       input logic [23:0] exp_bin, input logic exp_err, input bit noisy);
        int n;
        bit busy_ok, hold_ok;
        @(negedge clk);
        check("ready_before", {31'd0, in_ready}, 32'd1);
        bcd_in = bcd;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_after_accept", {31'd0, in_ready}, 32'd0);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 40) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                bcd_in = 12'($urandom);
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (in_ready) busy_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("latency", n, exp_lat);
        check("bin_out", {8'd0, bin_out}, {8'd0, exp_bin});
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("busy_no_ready", {31'd0, busy_ok}, 32'd1);
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || bin_out !== exp_bin || err !== exp_err || in_ready) hold_ok = 1'b0;
        end
        if (stall > 0) check("hold", {31'd0, hold_ok}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_valid", {31'd0, out_valid}, 32'd0);
        check("handoff_ready", {31'd0, in_ready}, 32'd1);
        check("handoff_err", {31'd0, err}, 32'd0);
        check("bin_retained", {8'd0, bin_out}, {8'd0, exp_bin});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bin", {8'd0, bin_out}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        run(12'h123, 0, 13, 24'd123, 1'b0, 1'b0);
        run(12'h000, 0, 13, 24'd0, 1'b0, 1'b1);
        run(12'h999, 0, 13, 24'h3E7, 1'b0, 1'b1);
        run(12'h500, 0, 13, 24'h1F4, 1'b0, 1'b1);
        run(12'h042, 20, 13, 24'd42, 1'b0, 1'b0);
        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        bcd_in = 12'h777;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_bin", {8'd0, bin_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(12'h001, 0, 13, 24'd1, 1'b0, 1'b0);
`ifdef BCD_CHECK_EN
        run(12'h1A3, 0, 1, 24'd0, 1'b1, 1'b0);
        run(12'h010, 0, 13, 24'd10, 1'b0, 1'b0);
`endif
        for (int v = 0; v < 1000; v++)
            run(to_bcd(v), $urandom_range(0, 3), 13, 24'(v), 1'b0, 1'b1);
        for (int k = 0; k < 50; k++) begin
            logic [11:0] b;
            b = to_bcd(int'($urandom_range(0, 999)));
            run(b, $urandom_range(0, 5), 13, 24'(bcd_value(b)), 1'b0, 1'b1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
